// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Shared definitions for the CPU memory bus: bus widths, the
//             responder state encoding and the read/write opcode values.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    // Responder FSM state encoding
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] WAIT   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] RESP   = 2'b11;

    // m_rw encoding
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder_if
//  Purpose  : Request/response handshake signals of the CPU memory bus.
//             The shared tri-state data bus is a plain inout on the responder.
//  Signals  : m_req   - request valid (level)
//             m_rw    - 0 = read, 1 = write
//             m_addr  - word address
//             m_ready - one-cycle response strobe
//             m_err   - error flag, valid while m_ready = 1
//  Modports : master (controller side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    import cpu_mem_pkg::*;

    logic              m_req;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic              m_ready;
    logic              m_err;

    modport master (
        output m_req, m_rw, m_addr,
        input  m_ready, m_err
    );

    modport slave (
        input  m_req, m_rw, m_addr,
        output m_ready, m_err
    );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : mem_array
//  Purpose  : Single-port synchronous RAM, DEPTH words of DATA_W bits, with a
//             write enable and a registered read port. Contents are not reset.
//  Ports    : clk   - clock
//             we    - write enable (writes wdata to addr)
//             re    - read enable (loads rdata from addr)
//             addr  - word index
//             wdata - write data
//             rdata - registered read data, holds until the next read
//  Revision : 1.0 - initial release
// ============================================================================
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  wire               clk,
    input  wire               we,
    input  wire               re,
    input  wire [IDX_W-1:0]   addr,
    input  wire [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory-side responder for the CPU memory bus. Serves one
//             request at a time from a word-addressed 32-bit RAM, with
//             WAIT_STATES extra cycles before the access, and drives the
//             shared data bus only while presenting read data.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous active-high reset
//             bus       - handshake signals (slave modport)
//             m_data    - tri-state data bus: write data in, read data out
//             rd_count  - successful reads   (MEM_STATS_EN only, saturating)
//             wr_count  - successful writes  (MEM_STATS_EN only, saturating)
//             err_count - error responses    (MEM_STATS_EN only, saturating)
//  Options  : `define MEM_STATS_EN adds the three statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0
) (
    input  wire               clk,
    input  wire               reset,
    mem_responder_if.slave    bus,
    inout  wire [DATA_W-1:0]  m_data
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [7:0]        err_count
`endif
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]       c_WAIT  = 4'(WAIT_STATES);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [3:0]        r_wait_cnt;
    logic              r_ready;
    logic              r_resp_err;
    logic              r_drive;
    logic [DATA_W-1:0] w_rdata;
    logic              w_oob;
    logic              w_accept;
    logic              w_mem_we;
    logic              w_mem_re;
    logic              w_resp;

    // Out-of-range check on the live address; no wrap into the array.
    assign w_oob    = ({1'b0, bus.m_addr} >= c_DEPTH);
    assign w_accept = (r_state == IDLE) && bus.m_req;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.m_req) begin
                    if (w_oob) begin
                        w_next = RESP;
                    end else if (c_WAIT == 4'd0) begin
                        w_next = ACCESS;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == 4'd1) begin
                    w_next = ACCESS;
                end
            end
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state. Errored requests never reach ACCESS,
    // so the RAM is untouched for them.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we = 1'b0;
        w_mem_re = 1'b0;
        w_resp   = 1'b0;
        case (r_state)
            ACCESS: begin
                w_mem_we = (r_rw == MEM_WR);
                w_mem_re = (r_rw == MEM_RD);
            end
            RESP:    w_resp = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and wait counter. Bus inputs are only looked at in
    // IDLE, so changes mid-transaction have no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw       <= MEM_RD;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= 4'd0;
        end else begin
            if (w_accept) begin
                r_rw       <= bus.m_rw;
                r_addr     <= bus.m_addr;
                r_err      <= w_oob;
                r_wait_cnt <= c_WAIT;
                if (bus.m_rw == MEM_WR) begin
                    r_wdata <= m_data;
                end
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response stage. m_ready, m_err and the bus enable are registered off
    // the RESP state so they change together and are glitch-free; the read
    // data register is stable from ACCESS onwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_resp_err <= 1'b0;
            r_drive    <= 1'b0;
        end else begin
            r_ready    <= w_resp;
            r_resp_err <= w_resp && r_err;
            r_drive    <= w_resp && !r_err && (r_rw == MEM_RD);
        end
    end

    assign bus.m_ready = r_ready;
    assign bus.m_err   = r_resp_err;
    assign m_data      = r_drive ? w_rdata : {DATA_W{1'bz}};

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_mem_we),
        .re    (w_mem_re),
        .addr  (r_addr[IDX_W-1:0]),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

`ifdef MEM_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics, bumped on the RESP edge of each transaction.
    // ------------------------------------------------------------------
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic [7:0]  r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_err_count <= '0;
        end else if (w_resp) begin
            if (r_err) begin
                if (r_err_count != '1) r_err_count <= r_err_count + 8'd1;
            end else if (r_rw == MEM_RD) begin
                if (r_rd_count != '1)  r_rd_count  <= r_rd_count + 16'd1;
            end else begin
                if (r_wr_count != '1)  r_wr_count  <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder. Three instances cover
//             WAIT_STATES = 0 (A), DEPTH = 1024 / WAIT_STATES = 3 (B) and
//             WAIT_STATES = 4 (C). Stimulus pushes expected responses into a
//             per-instance queue; a negedge monitor pops and compares them.
//  Options  : MEM_STATS_EN enables the statistics counter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    import cpu_mem_pkg::*;

    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [2:0]  wen;
    logic [11:0] addr [3];
    logic [31:0] wdat [3];

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();
    mem_responder_if bus_c ();

    wire [31:0] data_a;
    wire [31:0] data_b;
    wire [31:0] data_c;

    assign bus_a.m_req  = req[0];
    assign bus_a.m_rw   = rw[0];
    assign bus_a.m_addr = addr[0];
    assign bus_b.m_req  = req[1];
    assign bus_b.m_rw   = rw[1];
    assign bus_b.m_addr = addr[1];
    assign bus_c.m_req  = req[2];
    assign bus_c.m_rw   = rw[2];
    assign bus_c.m_addr = addr[2];

    assign data_a = wen[0] ? wdat[0] : 32'hzzzzzzzz;
    assign data_b = wen[1] ? wdat[1] : 32'hzzzzzzzz;
    assign data_c = wen[2] ? wdat[2] : 32'hzzzzzzzz;

`ifdef MEM_STATS_EN
    wire [15:0] rd_a, wr_a, rd_b, wr_b, rd_c, wr_c;
    wire [7:0]  er_a, er_b, er_c;
`endif

    mem_responder #(.DEPTH(4096), .WAIT_STATES(0)) dut_a (
        .clk (clk), .reset (rst[0]), .bus (bus_a), .m_data (data_a)
`ifdef MEM_STATS_EN
        , .rd_count (rd_a), .wr_count (wr_a), .err_count (er_a)
`endif
    );

    mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut_b (
        .clk (clk), .reset (rst[1]), .bus (bus_b), .m_data (data_b)
`ifdef MEM_STATS_EN
        , .rd_count (rd_b), .wr_count (wr_b), .err_count (er_b)
`endif
    );

    mem_responder #(.DEPTH(4096), .WAIT_STATES(4)) dut_c (
        .clk (clk), .reset (rst[2]), .bus (bus_c), .m_data (data_c)
`ifdef MEM_STATS_EN
        , .rd_count (rd_c), .wr_count (wr_c), .err_count (er_c)
`endif
    );

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // An undriven bus reads as Z in a 4-state simulator and as 0 in a
    // 2-state one; all read data used here is nonzero to keep that distinct.
    task automatic chk_rel(input string name, input logic [31:0] dat);
        n_vec++;
        if (!((dat === 32'hzzzzzzzz) || (dat === 32'h0))) begin
            n_fail++;
            $display("FAIL %s: m_data=%h, required hi-Z (cycle %0d)", name, dat, cyc);
        end
    endtask

    task automatic push(input int ch, input exp_t e);
        case (ch)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic pop(input int ch, output exp_t e);
        case (ch)
            0:       e = qa.pop_front();
            1:       e = qb.pop_front();
            default: e = qc.pop_front();
        endcase
    endtask

    task automatic mon(input int ch, input logic rdy, input logic er,
                       input logic [31:0] dat, input logic drv);
        exp_t e;
        if (rdy === 1'b1) begin
            if (qsize(ch) == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_ready ch%0d: got m_ready=1, required 0 (cycle %0d)", ch, cyc);
            end else begin
                pop(ch, e);
                chk($sformatf("latency ch%0d", ch), cyc, e.due);
                chk($sformatf("m_err ch%0d", ch), 32'(er), 32'(e.err));
                if (e.rd && !e.err)
                    chk($sformatf("rdata ch%0d", ch), dat, e.data);
                else
                    chk_rel($sformatf("resp_bus ch%0d", ch), dat);
            end
        end else if (!drv) begin
            chk_rel($sformatf("idle_bus ch%0d", ch), dat);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.m_ready, bus_a.m_err, data_a, wen[0]);
        mon(1, bus_b.m_ready, bus_b.m_err, data_b, wen[1]);
        mon(2, bus_c.m_ready, bus_c.m_err, data_c, wen[2]);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Called mid-cycle; the next rising edge samples.
    // ------------------------------------------------------------------
    task automatic issue(input int ch, input logic is_wr, input logic [11:0] a,
                         input logic [31:0] d, input logic e_err, input int lat);
        exp_t e;
        req[ch]  = 1'b1;
        rw[ch]   = is_wr;
        addr[ch] = a;
        wdat[ch] = d;
        wen[ch]  = is_wr;
        e.due    = cyc + 1 + lat;
        e.err    = e_err;
        e.rd     = !is_wr;
        e.data   = d;
        push(ch, e);
        @(posedge clk); #1;
        req[ch] = 1'b0;
        wen[ch] = 1'b0;
    endtask

    task automatic wait_done(input int ch);
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            if (qsize(ch) == 0) break;
            @(posedge clk); #1;
        end
        if (qsize(ch) != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout ch%0d: %0d responses outstanding, required 0", ch, qsize(ch));
            while (qsize(ch) != 0) pop(ch, e);
        end
    endtask

    task automatic txn(input int ch, input logic is_wr, input logic [11:0] a,
                       input logic [31:0] d, input logic e_err, input int lat);
        issue(ch, is_wr, a, d, e_err, lat);
        wait_done(ch);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int unsigned n0;
        rst = 3'b111;
        req = 3'b000;
        rw  = 3'b000;
        wen = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 12'h000;
            wdat[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset m_ready A", 32'(bus_a.m_ready), 32'h0);
        chk("reset m_err A",   32'(bus_a.m_err),   32'h0);
        chk("reset m_ready B", 32'(bus_b.m_ready), 32'h0);
        chk("reset m_ready C", 32'(bus_c.m_ready), 32'h0);
        chk_rel("reset bus A", data_a);
        chk_rel("reset bus C", data_c);
`ifdef MEM_STATS_EN
        chk("reset rd_count", 32'(rd_b), 32'h0);
`endif
        rst = 3'b000;
        @(posedge clk); #1;

        // A: zero wait states, write/read incl. top address
        txn(0, 1'b1, 12'h005, 32'hDEADBEEF, 1'b0, 2);
        txn(0, 1'b0, 12'h005, 32'hDEADBEEF, 1'b0, 2);
        txn(0, 1'b1, 12'hFFF, 32'h600DF00D, 1'b0, 2);
        txn(0, 1'b0, 12'hFFF, 32'h600DF00D, 1'b0, 2);
        txn(0, 1'b0, 12'h005, 32'hDEADBEEF, 1'b0, 2);

        // A: held request, address changes mid-transaction
        txn(0, 1'b1, 12'h020, 32'h0A0A0A0A, 1'b0, 2);
        txn(0, 1'b1, 12'h021, 32'h0B0B0B0B, 1'b0, 2);
        req[0]  = 1'b1;
        rw[0]   = 1'b0;
        addr[0] = 12'h020;
        n0 = cyc + 1;
        push(0, '{due: n0 + 2, err: 1'b0, rd: 1'b1, data: 32'h0A0A0A0A});
        push(0, '{due: n0 + 5, err: 1'b0, rd: 1'b1, data: 32'h0B0B0B0B});
        @(posedge clk); #1;
        addr[0] = 12'h021;
        while (cyc < n0 + 5) begin
            @(posedge clk); #1;
        end
        req[0] = 1'b0;
        wait_done(0);
        repeat (4) @(posedge clk);
        #1;

        // B: DEPTH 1024, 3 wait states, out-of-range without aliasing
        txn(1, 1'b1, 12'h000, 32'h11223344, 1'b0, 5);
        txn(1, 1'b0, 12'h000, 32'h11223344, 1'b0, 5);
        txn(1, 1'b1, 12'h400, 32'hBAD0BAD0, 1'b1, 1);
        txn(1, 1'b0, 12'h000, 32'h11223344, 1'b0, 5);
        txn(1, 1'b1, 12'h3FF, 32'h55AA55AA, 1'b0, 5);
        txn(1, 1'b0, 12'h3FF, 32'h55AA55AA, 1'b0, 5);
`ifdef MEM_STATS_EN
        chk("rd_count",  32'(rd_b), 32'd3);
        chk("wr_count",  32'(wr_b), 32'd2);
        chk("err_count", 32'(er_b), 32'd1);
        force dut_b.r_rd_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut_b.r_rd_count;
        txn(1, 1'b0, 12'h000, 32'h11223344, 1'b0, 5);
        chk("rd_count saturated", 32'(rd_b), 32'h0000FFFF);
`endif
        txn(1, 1'b0, 12'h400, 32'h0, 1'b1, 1);
        txn(1, 1'b0, 12'hFFF, 32'h0, 1'b1, 1);

        // C: 4 wait states, reset during WAIT discards the write
        txn(2, 1'b1, 12'h010, 32'hCAFEF00D, 1'b0, 6);
        txn(2, 1'b0, 12'h010, 32'hCAFEF00D, 1'b0, 6);
        req[2]  = 1'b1;
        rw[2]   = 1'b1;
        addr[2] = 12'h010;
        wdat[2] = 32'h12345678;
        wen[2]  = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        wen[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        #1;
        chk("mid-reset m_ready C", 32'(bus_c.m_ready), 32'h0);
        chk_rel("mid-reset bus C", data_c);
        repeat (3) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        txn(2, 1'b0, 12'h010, 32'hCAFEF00D, 1'b0, 6);

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
